// File: rtl/pll_reset_seq.sv
// PLL lock qualifier and system reset sequencer with unlock event counting.
// Optional PLL_STDY_CHECK_EN: also treat a dropped sticky-lock as an unlock and pulse stdy_rst_out in REARM.
module pll_reset_seq #(
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 8
) (
    input  logic             clock_in,
    input  logic             rst_n_in,
    input  logic             pll_locked_in,
    input  logic             pll_stdy_in,
    output logic             sys_rst_n_out,
    output logic             ready_out,
    output logic             stdy_rst_out,
    output logic             unlock_evt_out,
    output logic [CNT_W-1:0] unlock_cnt_out
);

    localparam int SC_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SC_W-1:0]  STABLE_LAST = SC_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RUN       = 2'd1,
        REARM     = 2'd2
    } state_t;

    // Two-flop synchronizers: bit 0 = lock, bit 1 = sticky lock
    logic [1:0] async_vec;
    logic [1:0] sync_vec;
    logic       lock_s;
    logic       stdy_s;

    assign async_vec = {pll_stdy_in, pll_locked_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic out_reg;
            always_ff @(posedge clock_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    meta_reg <= 1'b0;
                    out_reg  <= 1'b0;
                end else begin
                    meta_reg <= async_vec[gi];
                    out_reg  <= meta_reg;
                end
            end
            assign sync_vec[gi] = out_reg;
        end
    endgenerate

    assign lock_s = sync_vec[0];
    assign stdy_s = sync_vec[1];

    logic unlock_det;
`ifdef PLL_STDY_CHECK_EN
    // A sub-cycle unlock may be missed by lock_s but leaves the sticky flag low
    assign unlock_det = !lock_s || !stdy_s;
`else
    logic unused_stdy_s;
    assign unused_stdy_s = stdy_s;
    assign unlock_det    = !lock_s;
`endif

    state_t          state_reg, state_next;
    logic [SC_W-1:0] stable_cnt_reg, stable_cnt_next;
    logic            rearm_cnt_reg, rearm_cnt_next;

    always_ff @(posedge clock_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg      <= WAIT_LOCK;
            stable_cnt_reg <= '0;
            rearm_cnt_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            stable_cnt_reg <= stable_cnt_next;
            rearm_cnt_reg  <= rearm_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        stable_cnt_next = '0;
        rearm_cnt_next  = 1'b0;
        case (state_reg)
            WAIT_LOCK: begin
                if (lock_s) begin
                    if (stable_cnt_reg == STABLE_LAST) begin
                        state_next = RUN;
                    end else begin
                        stable_cnt_next = stable_cnt_reg + 1'b1;
                    end
                end
            end
            RUN: begin
                if (unlock_det) begin
                    state_next = REARM;
                end
            end
            REARM: begin
                // Fixed two-cycle rearm, independent of lock status
                if (rearm_cnt_reg) begin
                    state_next = WAIT_LOCK;
                end else begin
                    rearm_cnt_next = 1'b1;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
            end
        endcase
    end

    logic             sys_rst_n_reg;
    logic             ready_reg;
    logic             unlock_evt_reg;
    logic [CNT_W-1:0] unlock_cnt_reg;
    logic             rearm_first;

    assign rearm_first = (state_reg == REARM) && !rearm_cnt_reg;

    always_ff @(posedge clock_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sys_rst_n_reg  <= 1'b0;
            ready_reg      <= 1'b0;
            unlock_evt_reg <= 1'b0;
            unlock_cnt_reg <= '0;
        end else begin
            sys_rst_n_reg  <= (state_reg == RUN);
            ready_reg      <= (state_reg == RUN);
            unlock_evt_reg <= rearm_first;
            if (rearm_first && (unlock_cnt_reg != CNT_MAX)) begin
                unlock_cnt_reg <= unlock_cnt_reg + 1'b1;
            end
        end
    end

    assign sys_rst_n_out  = sys_rst_n_reg;
    assign ready_out      = ready_reg;
    assign unlock_evt_out = unlock_evt_reg;
    assign unlock_cnt_out = unlock_cnt_reg;

`ifdef PLL_STDY_CHECK_EN
    assign stdy_rst_out = (state_reg == REARM);
`else
    assign stdy_rst_out = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed and randomized bench for pll_reset_seq with an edge-timestamp reference model.
module tb_pll_reset_seq;

    localparam int STABLE  = 8;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef PLL_STDY_CHECK_EN
    localparam bit STDY_EN = 1'b1;
`else
    localparam bit STDY_EN = 1'b0;
`endif

    localparam int M_WAIT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_REARM = 2;

    logic          clock_in = 1'b0;
    logic          rst_n_in = 1'b1;
    logic          pll_locked_in = 1'b0;
    logic          pll_stdy_in = 1'b0;
    logic          sys_rst_n_out;
    logic          ready_out;
    logic          stdy_rst_out;
    logic          unlock_evt_out;
    logic [CW-1:0] unlock_cnt_out;

    pll_reset_seq #(.STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
        .clock_in      (clock_in),
        .rst_n_in      (rst_n_in),
        .pll_locked_in (pll_locked_in),
        .pll_stdy_in   (pll_stdy_in),
        .sys_rst_n_out (sys_rst_n_out),
        .ready_out     (ready_out),
        .stdy_rst_out  (stdy_rst_out),
        .unlock_evt_out(unlock_evt_out),
        .unlock_cnt_out(unlock_cnt_out)
    );

    always #5 clock_in = ~clock_in;

    int checks = 0;
    int passes = 0;

    // Reference model: raw input history indexed by edge number since reset release
    bit rh[$];
    bit sh[$];
    int m_n, m_mode, m_ws, m_last_low, m_u, m_cnt;
    bit exp_sys, exp_evt, exp_stdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s obs=%0d exp=%0d", tag, obs, expv);
    endtask

    task automatic model_reset();
        rh.delete();
        sh.delete();
        m_n = 0; m_mode = M_WAIT; m_ws = 0; m_last_low = -1; m_u = -10; m_cnt = 0;
    endtask

    // Raw sample at edge k is seen by the state decision at edge k+2
    task automatic model_edge(input bit lk, input bit sd);
        int prev, base;
        bit lk2, sd2;
        prev = m_mode;
        rh.push_back(lk);
        sh.push_back(sd);
        lk2 = (m_n >= 2) ? rh[m_n-2] : 1'b0;
        sd2 = (m_n >= 2) ? sh[m_n-2] : 1'b0;
        case (prev)
            M_WAIT: begin
                if (m_n - 2 >= m_ws && !lk2) m_last_low = m_n - 2;
                base = (m_last_low > m_ws - 1) ? m_last_low : m_ws - 1;
                if ((m_n - 2) - base >= STABLE) m_mode = M_RUN;
            end
            M_RUN: begin
                if (!lk2 || (STDY_EN && !sd2)) begin
                    m_mode = M_REARM;
                    m_u = m_n;
                end
            end
            default: begin
                if (m_n == m_u + 2) begin
                    m_mode = M_WAIT;
                    m_ws = m_n - 1;
                    m_last_low = m_ws - 1;
                end
            end
        endcase
        exp_sys  = (prev == M_RUN);
        exp_evt  = (prev == M_REARM) && (m_n == m_u + 1);
        if (exp_evt && m_cnt < CNT_MAX) m_cnt++;
        exp_stdy = STDY_EN && (m_mode == M_REARM);
        m_n++;
    endtask

    task automatic step(input bit lk, input bit sd);
        pll_locked_in = lk;
        pll_stdy_in   = sd;
        @(posedge clock_in);
        model_edge(lk, sd);
        #1;
        chk("sys_rst_n", sys_rst_n_out, exp_sys);
        chk("ready", ready_out, exp_sys);
        chk("unlock_evt", unlock_evt_out, exp_evt);
        chk("unlock_cnt", unlock_cnt_out, m_cnt);
        chk("stdy_rst", stdy_rst_out, exp_stdy);
        $display("edge %0d lock=%0b stdy=%0b -> sys=%0b rdy=%0b evt=%0b cnt=%0d srst=%0b",
                 m_n - 1, lk, sd, sys_rst_n_out, ready_out, unlock_evt_out, unlock_cnt_out, stdy_rst_out);
        @(negedge clock_in);
    endtask

    task automatic do_reset();
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("rst_sys", sys_rst_n_out, 0);
        chk("rst_ready", ready_out, 0);
        chk("rst_evt", unlock_evt_out, 0);
        chk("rst_cnt", unlock_cnt_out, 0);
        chk("rst_stdy", stdy_rst_out, 0);
        $display("reset asserted: sys=%0b rdy=%0b evt=%0b cnt=%0d srst=%0b",
                 sys_rst_n_out, ready_out, unlock_evt_out, unlock_cnt_out, stdy_rst_out);
        model_reset();
        @(posedge clock_in);
        @(posedge clock_in);
        @(negedge clock_in);
        rst_n_in = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Uninterrupted lock: release exactly 10 edges after the first high sample
        for (int i = 0; i < 10; i++) step(1, 1);
        chk("s1_edge9_held", sys_rst_n_out, 0);
        step(1, 1);
        chk("s1_edge10_rel", sys_rst_n_out, 1);
        chk("s1_cnt0", unlock_cnt_out, 0);

        // One-cycle glitch restarts qualification
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1);
        step(0, 1);
        for (int i = 0; i < 14; i++) step(1, 1);

        // Unlock in RUN
        step(0, 1);
        for (int i = 0; i < 14; i++) step(1, 1);

        // Repeated unlocks saturate the counter
        for (int k = 0; k < 5; k++) begin
            step(0, 1);
            step(0, 1);
            for (int i = 0; i < 14; i++) step(1, 1);
        end
        chk("sat_cnt", unlock_cnt_out, CNT_MAX);

        // Reset mid-RUN, then full requalification
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 1);

        // Sticky-lock drop while locked in RUN
        step(1, 0);
        for (int i = 0; i < 14; i++) step(1, 1);

        // Reset in the middle of REARM records no event
        step(0, 1);
        for (int i = 0; i < 3; i++) step(1, 1);
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 1);
        chk("rearm_abort_cnt", unlock_cnt_out, 0);

        // Randomized lock/sticky waveforms with occasional resets
        for (int seg = 0; seg < 45; seg++) begin
            int hl, ll;
            hl = $urandom_range(4, 24);
            ll = $urandom_range(1, 3);
            for (int i = 0; i < hl; i++) step(1'b1, $urandom_range(0, 24) != 0);
            for (int i = 0; i < ll; i++) step(1'b0, $urandom_range(0, 1) != 0);
            if (seg % 15 == 14) do_reset();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 1024, giving the number of consecutive synchronized-locked cycles required before reset release; legal range 2..65535.
REQ-002 The module SHALL have parameter CNT_W, default 8, giving the width of the unlock event counter; legal range 1..16.
REQ-003 clock_in  input  1  The module SHALL use this as its only clock, the buffered PLL output clock.
REQ-004 rst_n_in  input  1  The module SHALL use this as its reset, which is asynchronous and active-low.
REQ-005 pll_locked_in  input  1  The module SHALL accept this as the raw PLL lock status, asynchronous to clock_in.
REQ-006 pll_stdy_in  input  1  The module SHALL accept this as the raw PLL sticky-lock status, asynchronous to clock_in.
REQ-007 sys_rst_n_out  output  1  The module SHALL drive this as the active-low system reset for downstream logic.
REQ-008 ready_out  output  1  The module SHALL drive this high only while in RUN.
REQ-009 stdy_rst_out  output  1  The module SHALL drive this as the sticky-lock rearm pulse to the PLL.
REQ-010 unlock_evt_out  output  1  The module SHALL drive this as a one-cycle pulse per detected unlock event.
REQ-011 unlock_cnt_out  output  CNT_W  The module SHALL drive this as the saturating count of unlock events.

Function
REQ-012 The module SHALL synchronize pll_locked_in and pll_stdy_in, each through two flops reset to 0, producing lock_s and stdy_s.
REQ-013 The module SHALL implement FSM states WAIT_LOCK, RUN and REARM, with WAIT_LOCK as the reset state.
REQ-014 In WAIT_LOCK, the stable counter SHALL increment on each cycle with lock_s=1 and SHALL clear on any cycle with lock_s=0.
REQ-015 In WAIT_LOCK, when lock_s=1 and the stable counter equals STABLE_CYCLES-1, the FSM SHALL enter RUN on the next edge.
REQ-016 sys_rst_n_out and ready_out SHALL be registered outputs equal to 1 exactly when the state is RUN, and 0 otherwise.
REQ-017 sys_rst_n_out SHALL rise exactly STABLE_CYCLES+2 edges after the first edge that samples pll_locked_in high, provided the lock is uninterrupted.
REQ-018 In RUN, lock_s=0 SHALL be an unlock event; the FSM SHALL go to REARM, and the next edge SHALL drive sys_rst_n_out=0, ready_out=0 and unlock_evt_out=1 for one cycle.
REQ-019 unlock_cnt_out SHALL increment by one per unlock event and SHALL saturate at 2^CNT_W-1 without wrap-around.
REQ-020 REARM SHALL last exactly 2 cycles and then return to WAIT_LOCK with the stable counter cleared, regardless of lock_s.
REQ-021 A lock loss that occurs during WAIT_LOCK or REARM SHALL NOT count as an unlock event.
REQ-022 A lock_s glitch of a single cycle in WAIT_LOCK SHALL restart the stable count from 0.

Reset
REQ-023 Assertion of rst_n_in SHALL immediately force state=WAIT_LOCK, stable counter=0, both synchronizers=0, sys_rst_n_out=0, ready_out=0, stdy_rst_out=0, unlock_evt_out=0 and unlock_cnt_out=0.
REQ-024 Reset asserted mid-RUN or mid-REARM SHALL abort the operation with no unlock event recorded.
REQ-025 After rst_n_in deasserts, the module SHALL require a full STABLE_CYCLES qualification before releasing sys_rst_n_out.

Configuration
REQ-026 With macro PLL_STDY_CHECK_EN defined, stdy_rst_out SHALL be 1 for exactly both REARM cycles.
REQ-027 With PLL_STDY_CHECK_EN defined, stdy_s=0 while lock_s=1 in RUN SHALL also be an unlock event, so a missed sub-cycle unlock glitch is caught.
REQ-028 Without PLL_STDY_CHECK_EN, stdy_rst_out SHALL be constant 0, pll_stdy_in SHALL be ignored, and REARM SHALL still last 2 cycles.

Verification (STABLE_CYCLES=8, CNT_W=2)
REQ-029 Scenario: pll_locked_in held 1 from edge 0 -> sys_rst_n_out and ready_out are 1 from edge 10 onward, and unlock_cnt_out=0.
REQ-030 Scenario: lock high 5 cycles, low 1 cycle, then high -> the count restarts and sys_rst_n_out rises 10 edges after the re-rise.
REQ-031 Scenario: in RUN, drop lock -> sys_rst_n_out=0 and unlock_evt_out=1 for one cycle 3 edges later, unlock_cnt_out=1, and with the macro, stdy_rst_out=1 for 2 cycles.
REQ-032 Scenario: 5 unlock/relock cycles -> unlock_cnt_out saturates at 3.
REQ-033 Scenario: rst_n_in pulsed low mid-RUN -> all outputs are 0 asynchronously, and the release repeats the 10-edge qualification.
REQ-034 Scenario (macro defined): in RUN, pll_stdy_in=0 with pll_locked_in=1 -> an unlock event and REARM occur; without the macro, no response.
